// File: rtl/alu_serial_sequencer.sv
// Bit-serial 32-bit ALU: a single 1-bit slice is stepped LSB first, and the
// slice carry-out is fed back as the carry-in of the next bit.
// One operation is accepted per start/done handshake.
module alu_serial_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [3:0]  ctrl_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        cout_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Decoded control word, in this bit order: {valid, a_invert, b_invert, sel[1:0], cin0}.
  function automatic logic [5:0] decode(input logic [3:0] op);
    case (op)
      OP_AND:  decode = 6'b1_0_0_00_0;
      OP_OR:   decode = 6'b1_0_0_01_0;
      OP_ADD:  decode = 6'b1_0_0_10_0;
      OP_SUB:  decode = 6'b1_0_1_10_1;
      OP_SLT:  decode = 6'b1_0_1_10_1;
      OP_NOR:  decode = 6'b1_1_1_00_0;
      default: decode = 6'b0_0_0_00_0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        carry_q, carry_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [5:0]  dec_cur, dec_new;
  logic        a_bit, b_bit, s_sum, s_cout, s_out;
  logic        is_arith, is_slt, ovf31;
  logic [31:0] fin;

  assign dec_cur  = decode(ctrl_q);
  assign dec_new  = decode(ctrl_i);
  assign is_arith = (ctrl_q == OP_ADD) || (ctrl_q == OP_SUB);
  assign is_slt   = (ctrl_q == OP_SLT);

  // One ALU bit slice, operating on bit cnt of the captured operands.
  always_comb begin
    a_bit  = a_q[cnt_q] ^ dec_cur[4];
    b_bit  = b_q[cnt_q] ^ dec_cur[3];
    s_sum  = a_bit ^ b_bit ^ carry_q;
    s_cout = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    case (dec_cur[2:1])
      2'b00:   s_out = a_bit & b_bit;
      2'b01:   s_out = a_bit | b_bit;
      2'b10:   s_out = s_sum;
      default: s_out = 1'b0;  // the less input stays 0 while bits are shifting
    endcase
  end

  // Next-state and datapath control for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    carry_d  = carry_q;
    sh_d     = sh_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    ovf31    = carry_q ^ s_cout;  // carry into bit 31 XOR carry out of bit 31
    fin      = {s_out, sh_q[30:0]};
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = src1_i;
          b_d     = src2_i;
          ctrl_d  = ctrl_i;
          cnt_d   = 5'd0;
          carry_d = dec_new[0];
          sh_d    = 32'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sh_d[cnt_q] = s_out;
        carry_d     = s_cout;
        if (cnt_q == 5'd31) begin
          // The fixups are registered on the edge into DONE, so the results
          // are already valid in the cycle that done_o is high.
          if (!dec_cur[5])  fin = 32'd0;
          else if (is_slt)  fin = {31'd0, s_sum ^ ovf31};
          result_d = fin;
          zero_d   = (fin == 32'd0);
          cout_d   = is_arith & s_cout;
          ovf_d    = is_arith & ovf31;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, with a synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      ctrl_q   <= 4'd0;
      carry_q  <= 1'b0;
      sh_q     <= 32'd0;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      carry_q  <= carry_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/alu_serial_sequencer.md
# alu_serial_sequencer

Bit-serial 32-bit ALU. Drives a single internal 1-bit ALU slice once per clock, LSB first, carrying the slice carry-out back to its carry-in. Accepts one operation per start/done handshake and returns a 32-bit result plus flags. It is the area-minimal alternative to the 32-slice ripple ALU in the datapath, for use by multi-cycle control.

## Interface
- No parameters; width fixed at 32, latency fixed.
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE
- src1_i  in  32  operand A, captured on accepted start
- src2_i  in  32  operand B, captured on accepted start
- ctrl_i  in  4  op, captured on accepted start:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
- busy_o  out  1  high from accept through DONE cycle
- done_o  out  1  one-cycle pulse; result/flags valid from this cycle
- result_o  out  32  result, held until next accepted start
- zero_o  out  1  result_o == 0
- cout_o  out  1  carry out of bit 31 (ADD/SUB only, else 0)
- overflow_o  out  1  signed overflow (ADD/SUB only, else 0)

## Operation
- Slice per bit i: a = A[i]^A_invert, b = B[i]^B_invert.
  - sel 00: AND
  - sel 01: OR
  - sel 10: sum a^b^cin, cout = majority(a, b, cin)
  - sel 11: less (forced 0 during shifting)
- Decode:
  - AND: Ainv 0, Binv 0, sel 00, cin0 0
  - OR: 0, 0, 01, 0
  - ADD: 0, 0, 10, 0
  - SUB: 0, 1, 10, 1
  - SLT: 0, 1, 10, 1; uses the sum bits internally
  - NOR: 1, 1, 00, 0
  - Any other code: result 0, flags 0, zero 1; full latency still applies.
- States:
  - IDLE: start_i=1 captures operands and ctrl, sets cnt=0, carry=cin0, and moves to SHIFT.
  - SHIFT: one bit per cycle. Result shift register takes the slice output into bit cnt and carry takes the slice cout. Record carry-in of bit 31 at cnt=31. At cnt==31, move to DONE; otherwise cnt+1.
  - DONE: apply fixups, assert done_o, return to IDLE.
- Fixups in DONE:
  - overflow = cin31 ^ cout31 for ADD, SUB and SLT (internal).
  - SLT: result = {31'b0, sum[31]^overflow}.
  - cout_o and overflow_o are exported only for ADD/SUB.
  - zero_o is computed on the final result.
- start_i outside IDLE is ignored; there is no queuing.
- Operand inputs may change freely after accept.

## Timing
- Reset values: state IDLE, cnt 0, busy_o 0, done_o 0, result_o 0, zero_o 0, cout_o 0, overflow_o 0.
- Sequence: start accepted at edge E0 → SHIFT for edges E1..E32 → DONE during the cycle after E32; done_o high in cycle 33 after accept.
- busy_o rises the cycle after E0 and falls with done_o going low.
- A new start is accepted the cycle after DONE, i.e. every 34 cycles back-to-back.
- start_i held high continuously: re-accepted in each IDLE cycle.
- result_o, zero_o, cout_o, overflow_o update only in DONE and are stable otherwise.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values; no done_o pulse for the aborted op.
- Reset and start together: reset wins.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, cout 0, zero 0; done_o exactly 33 cycles after start.
- SUB 0x00000005 − 0x00000005 → result 0, zero 1, cout 1, overflow 0; SUB 0x80000000 − 1 → 0x7FFFFFFF, overflow 1.
- SLT with src1 0x80000000, src2 0x00000001 → 1. SLT with src1 0x7FFFFFFF, src2 0xFFFFFFFF → 0. Both cases: cout_o 0, overflow_o 0.
- AND/OR/NOR with 0xF0F0F0F0 and 0xFF00FF00 → 0xF000F000 / 0xFFF0FFF0 / 0x000F000F.
- start pulsed during SHIFT with different operands → ignored. The first result is unchanged, and done_o pulses exactly once.
- rst_i at cycle 10 of an ADD → outputs zero next cycle, no done_o. Unsupported ctrl 1111 → result 0, zero 1 after 33 cycles.
